// File: rtl/time_pkg.sv
// Shared constants and mode encoding for the time-of-day counter and its display decoders.
// The 12-hour limits are used when TIME_COUNTER_12H_EN is defined.
package time_pkg;

  localparam int TIME_W = 6;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;

  // 12-hour display runs 12,1..11; the AM/PM flip happens leaving 11.
  localparam logic [TIME_W-1:0] HOUR12_MIN     = 6'd1;
  localparam logic [TIME_W-1:0] HOUR12_MAX     = 6'd12;
  localparam logic [TIME_W-1:0] HOUR12_PM_EDGE = 6'd11;

  // Mode sequence on btn_mode; the unused encoding falls back to RUN.
  function automatic mode_e next_mode(input mode_e cur, input logic adv);
    mode_e nxt;
    nxt = MODE_RUN;
    case (cur)
      MODE_RUN:      nxt = adv ? MODE_SET_HOUR : MODE_RUN;
      MODE_SET_HOUR: nxt = adv ? MODE_SET_MIN  : MODE_SET_HOUR;
      MODE_SET_MIN:  nxt = adv ? MODE_RUN      : MODE_SET_MIN;
      default:       nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/time_counter_mod_counter.sv
// Registered LO..HI wrapping counter used for the sec, min and hour fields.
// carry pulses combinationally when an accepted increment wraps HI back to LO.
module mod_counter
  import time_pkg::*;
#(
  parameter logic [TIME_W-1:0] LO  = '0,
  parameter logic [TIME_W-1:0] HI  = SEC_MAX,
  parameter logic [TIME_W-1:0] RST = LO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              inc,
  input  logic              clr,
  output logic [TIME_W-1:0] value,
  output logic              carry
);

  logic [TIME_W-1:0] value_q;
  logic [TIME_W-1:0] value_d;
  logic              at_hi;

  // >= rather than == so a field can never escape its legal range.
  assign at_hi = (value_q >= HI);

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = LO;
    end else if (en && inc) begin
      value_d = at_hi ? LO : value_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RST;
    end else begin
      value_q <= value_d;
    end
  end

  assign carry = en && inc && !clr && at_hi;
  assign value = value_q;

endmodule

// File: rtl/time_counter.sv
// Binary time-of-day counter: prescaler, sec/min/hour chain and a set-time mode FSM.
// Define TIME_COUNTER_12H_EN for 12-hour counting with an AM/PM flag.
module time_counter
  import time_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] hour,
  output logic              pm,
  output logic [1:0]        mode,
  output logic              sec_tick,
  output logic              day_pulse
);

  localparam int            PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

`ifdef TIME_COUNTER_12H_EN
  localparam logic [TIME_W-1:0] HOUR_LO  = HOUR12_MIN;
  localparam logic [TIME_W-1:0] HOUR_HI  = HOUR12_MAX;
  localparam logic [TIME_W-1:0] HOUR_RST = HOUR12_MAX;
`else
  localparam logic [TIME_W-1:0] HOUR_LO  = '0;
  localparam logic [TIME_W-1:0] HOUR_HI  = HOUR_MAX;
  localparam logic [TIME_W-1:0] HOUR_RST = '0;
`endif

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_pulse_q, day_pulse_d;

  logic run, tick, exit_set, set_hour_inc, set_min_inc;
  logic min_inc, hour_inc;
  logic sec_carry, min_carry;
  logic [TIME_W-1:0] sec_v, min_v, hour_v;

  always_comb begin
    run          = (mode_q == MODE_RUN);
    tick         = run && (presc_q == PRE_LAST);
    exit_set     = (mode_q == MODE_SET_MIN) && btn_mode;
    // A mode press in the same cycle swallows the increment.
    set_hour_inc = (mode_q == MODE_SET_HOUR) && btn_inc && !btn_mode;
    set_min_inc  = (mode_q == MODE_SET_MIN)  && btn_inc && !btn_mode;
    min_inc      = sec_carry || set_min_inc;
    hour_inc     = (run && min_carry) || set_hour_inc;
  end

  always_comb begin
    mode_d      = next_mode(mode_q, btn_mode);
    presc_d     = presc_q;
    sec_tick_d  = tick;
    if (tick) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end else if (exit_set) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RUN;
      presc_q     <= '0;
      sec_tick_q  <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      sec_tick_q  <= sec_tick_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  mod_counter #(.LO('0), .HI(SEC_MAX), .RST('0)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .inc   (tick),
    .clr   (exit_set),
    .value (sec_v),
    .carry (sec_carry)
  );

  mod_counter #(.LO('0), .HI(MIN_MAX), .RST('0)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_v),
    .carry (min_carry)
  );

`ifdef TIME_COUNTER_12H_EN
  logic pm_q, pm_d;

  mod_counter #(.LO(HOUR_LO), .HI(HOUR_HI), .RST(HOUR_RST)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour_v),
    .carry ()
  );

  // 11->12 flips AM/PM; leaving 11 PM in RUN is the day boundary.
  always_comb begin
    pm_d        = pm_q ^ (hour_inc && (hour_v == HOUR12_PM_EDGE));
    day_pulse_d = run && min_carry && (hour_v == HOUR12_PM_EDGE) && pm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign pm = pm_q;
`else
  logic hour_carry;

  mod_counter #(.LO(HOUR_LO), .HI(HOUR_HI), .RST(HOUR_RST)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour_v),
    .carry (hour_carry)
  );

  always_comb begin
    day_pulse_d = run && hour_carry;
  end

  assign pm = 1'b0;
`endif

  assign sec       = sec_v;
  assign min       = min_v;
  assign hour      = hour_v;
  assign mode      = mode_q;
  assign sec_tick  = sec_tick_q;
  assign day_pulse = day_pulse_q;

endmodule
